// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    localparam int CNT_W = 4;
endpackage

// File: rtl/lane_align.sv
// Store byte-lane steering and load extraction/extension for one access.
// MEM_RESP_MISALIGN_ERR_EN: misaligned half/word raises align_err instead of rounding down.
module lane_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            addr_lo,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rword,
    output logic [DATA_WIDTH-1:0] wmask,
    output logic [DATA_WIDTH-1:0] wdata_sh,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  size_err,
    output logic                  align_err
);
    logic [1:0]            lane;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] size_mask;
    logic [DATA_WIDTH-1:0] raw;
    logic                  sign;

    always_comb begin
        lane      = addr_lo;
        align_err = 1'b0;
        size_err  = (size == SIZE_RSV);
        size_mask = '0;
        case (size)
            SIZE_B:  size_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
            SIZE_H:  size_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
            SIZE_W:  size_mask = {{(DATA_WIDTH-32){1'b0}}, 32'hFFFF_FFFF};
            default: size_mask = '0;
        endcase
`ifdef MEM_RESP_MISALIGN_ERR_EN
        align_err = ((size == SIZE_H) && addr_lo[0]) ||
                    ((size == SIZE_W) && (addr_lo != 2'b00));
`else
        // Round down to the natural alignment of the access size.
        if (size == SIZE_H) begin
            lane = {addr_lo[1], 1'b0};
        end else if (size == SIZE_W) begin
            lane = 2'b00;
        end
`endif
        shamt    = {lane, 3'b000};
        wmask    = size_mask << shamt;
        wdata_sh = (wdata & size_mask) << shamt;
        raw      = (rword >> shamt) & size_mask;
        sign     = 1'b0;
        case (size)
            SIZE_B:  sign = raw[7];
            SIZE_H:  sign = raw[15];
            SIZE_W:  sign = raw[31];
            default: sign = 1'b0;
        endcase
        rdata = (sign && !is_unsigned) ? (raw | ~size_mask) : raw;
    end
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed wait-state latency.
// MEM_RESP_MISALIGN_ERR_EN (in lane_align) turns misaligned half/word accesses into errors.
//
// state   | meaning
// IDLE    | req_ready=1, waiting for a request to capture
// WAIT    | counting wait states; access happens when count reaches 1
// RESP    | rsp_valid=1, holding response until rsp_ready
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt;

    logic                  cap_we;
    logic [31:0]           cap_addr;
    logic [1:0]            cap_size;
    logic                  cap_unsigned;
    logic [DATA_WIDTH-1:0] cap_wdata;

    logic                  op_we;
    logic [31:0]           op_addr;
    logic [1:0]            op_size;
    logic                  op_unsigned;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [IDX_W-1:0]      op_idx;
    logic                  range_err;
    logic                  op_err;
    logic                  access_go;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rword;
    logic [DATA_WIDTH-1:0] la_wmask;
    logic [DATA_WIDTH-1:0] la_wdata;
    logic [DATA_WIDTH-1:0] la_rdata;
    logic                  la_size_err;
    logic                  la_align_err;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (req_valid) state_nx = (LATENCY == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == CNT_W'(1)) state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // With zero latency the access uses the live request on its accept edge.
    always_comb begin
        if (state == ST_IDLE) begin
            op_we       = req_we;
            op_addr     = req_addr;
            op_size     = req_size;
            op_unsigned = req_unsigned;
            op_wdata    = req_wdata;
        end else begin
            op_we       = cap_we;
            op_addr     = cap_addr;
            op_size     = cap_size;
            op_unsigned = cap_unsigned;
            op_wdata    = cap_wdata;
        end
    end

    assign op_idx    = op_addr[IDX_W+1:2];
    assign range_err = ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign op_err    = range_err | la_size_err | la_align_err;
    assign access_go = rst && (((state == ST_IDLE) && req_valid && (LATENCY == 0)) ||
                               ((state == ST_WAIT) && (cnt == CNT_W'(1))));
    assign rword     = mem[op_idx];

    lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_align (
        .addr_lo    (op_addr[1:0]),
        .size       (op_size),
        .is_unsigned(op_unsigned),
        .wdata      (op_wdata),
        .rword      (rword),
        .wmask      (la_wmask),
        .wdata_sh   (la_wdata),
        .rdata      (la_rdata),
        .size_err   (la_size_err),
        .align_err  (la_align_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            cap_we       <= 1'b0;
            cap_addr     <= '0;
            cap_size     <= SIZE_B;
            cap_unsigned <= 1'b0;
            cap_wdata    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && req_valid) begin
                cnt          <= CNT_W'(LATENCY);
                cap_we       <= req_we;
                cap_addr     <= req_addr;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
                cap_wdata    <= req_wdata;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access_go) begin
                rsp_err   <= op_err;
                rsp_rdata <= (op_err || op_we) ? '0 : la_rdata;
            end
        end
    end

    // Storage is deliberately not reset; reset holds state in IDLE so no write can occur.
    always_ff @(posedge clk) begin
        if (access_go && op_we && !op_err) begin
            mem[op_idx] <= (rword & ~la_wmask) | (la_wdata & la_wmask);
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a byte-array reference model.
module tb_mem_responder;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [1:0]    req_size = '0;
    logic          req_unsigned = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] mb [0:DEPTH*4-1];

    always #5 clk = ~clk;

    mem_responder #(
        .DATA_WIDTH (DW),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: little-endian byte memory, accesses of 1/2/4 bytes.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rd);
        int nb;
        int base;
        logic [31:0] v;
        err = 1'b0;
        rd  = '0;
        if (size == 2'b11) begin
            err = 1'b1;
            return;
        end
        nb = 1 << size;
        if (addr >= 32'(DEPTH * 4)) err = 1'b1;
`ifdef MEM_RESP_MISALIGN_ERR_EN
        if ((addr % nb) != 0) err = 1'b1;
`endif
        if (err) return;
        base = int'(addr) - int'(addr % nb);
        if (we) begin
            for (int i = 0; i < nb; i++) mb[base+i] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[base+i];
            if (!uns && v[8*nb-1]) begin
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            rd = v;
        end
    endtask

    task automatic scramble(input logic v);
        req_valid    = v;
        req_we       = 1'($urandom);
        req_addr     = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the handshake edge.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input int hold, output logic err_o, output logic [31:0] rd_o);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          n;
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        model_access(we, addr, size, uns, wdata, exp_err, exp_rd);
        @(posedge clk); #1;
        n = 1;
        while (!rsp_valid && n < 40) begin
            scramble(1'($urandom));
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LAT + 1));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
        err_o = rsp_err;
        rd_o  = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            scramble(1'($urandom));
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
            chk({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        scramble(1'b0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_post_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [1:0]  size;
        int          pick;

        for (int i = 0; i < DEPTH * 4; i++) mb[i] = 8'h00;

        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        do_req("w10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, e, rd);
        chk("w10_err_lit", 32'(e), 32'd0);
        do_req("r10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, e, rd);
        chk("r10_lit", rd, 32'hDEADBEEF);

        do_req("wb13", 1'b1, 32'h13, 2'b00, 1'b0, 32'h80, 1, e, rd);
        do_req("rb13s", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, e, rd);
        chk("rb13s_lit", rd, 32'hFFFFFF80);
        do_req("rb13u", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, e, rd);
        chk("rb13u_lit", rd, 32'h00000080);
        do_req("r10b", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5, e, rd);
        chk("r10b_lit", rd, 32'h80ADBEEF);

        // Reset in the middle of WAIT must drop the store.
        do_req("w20", 1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, 0, e, rd);
        do_req("r10c", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, e, rd);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_size  = 2'b10;
        req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_err", 32'(rsp_err), 32'd0);
        chk("abort_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        do_req("r20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, e, rd);
        chk("r20_lit", rd, 32'hCAFEF00D);

        do_req("rh21", 1'b0, 32'h21, 2'b01, 1'b1, 32'h0, 0, e, rd);
`ifdef MEM_RESP_MISALIGN_ERR_EN
        chk("rh21_err_lit", 32'(e), 32'd1);
        chk("rh21_rd_lit", rd, 32'd0);
`else
        chk("rh21_err_lit", 32'(e), 32'd0);
        chk("rh21_rd_lit", rd, 32'h0000F00D);
`endif

        for (int w = 0; w < 16; w++) begin
            do_req("init", 1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom, 0, e, rd);
        end

        do_req("oor_r", 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, 0, e, rd);
        chk("oor_r_err_lit", 32'(e), 32'd1);
        chk("oor_r_rd_lit", rd, 32'd0);
        do_req("oor_w", 1'b1, 32'h1000, 2'b10, 1'b0, 32'hA5A5A5A5, 0, e, rd);
        chk("oor_w_err_lit", 32'(e), 32'd1);
        for (int w = 0; w < 16; w++) begin
            do_req("oor_scan", 1'b0, 32'(w * 4), 2'b10, 1'b0, 32'h0, 0, e, rd);
        end

        do_req("rsv", 1'b0, 32'h8, 2'b11, 1'b0, 32'h0, 0, e, rd);
        chk("rsv_err_lit", 32'(e), 32'd1);

        for (int t = 0; t < 150; t++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0) addr = 32'h1000 + 32'($urandom_range(0, 63));
            else if (pick == 1) addr = $urandom | 32'h8000_0000;
            else addr = 32'($urandom_range(0, 63));
            pick = $urandom_range(0, 9);
            size = (pick == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_req("rnd", 1'($urandom), addr, size, 1'($urandom), $urandom,
                   $urandom_range(0, 3), e, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width in bits.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of DATA_WIDTH-bit words stored.
REQ-003 Parameter LATENCY, default 2: wait-state cycles between request acceptance and response, legal range 0..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  core presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_size  input  2  00 byte, 01 half, 10 word; 11 is reserved.
REQ-011 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  core accepts the response.
REQ-015 rsp_rdata  output  DATA_WIDTH  load result, extended; 0 for stores and errors.
REQ-016 rsp_err  output  1  request failed; no memory change.

Function
REQ-017 FSM states are IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: when req_valid is 1, capture all req_* fields and load the wait counter with LATENCY; next state is WAIT if LATENCY>0, otherwise RESP.
REQ-019 WAIT: the counter decrements each cycle; at count 1, perform the access and go to RESP.
REQ-020 When LATENCY=0, the access is performed on the accept edge, and the response appears on the next cycle.
REQ-021 RESP: rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_ready=1; the state then returns to IDLE.
REQ-022 A request and a response are never in flight together; a new request is accepted one cycle after the response handshake at the earliest.
REQ-023 Word index = addr[31:2]; byte lane = addr[1:0]. A store writes only the addressed byte, half or word lanes.
REQ-024 A load selects the lanes and shifts them to bit 0, then sign- or zero-extends per req_unsigned.
REQ-025 A word index ≥ DEPTH_WORDS, or req_size=11, SHALL set rsp_err=1, suppress the write and force rsp_rdata=0.
REQ-026 Changes on req_* lines while not in IDLE SHALL be ignored.

Reset
REQ-027 Asserting rst (low) SHALL immediately force state=IDLE, counter=0, rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-028 Memory array contents are not reset.
REQ-029 Reset asserted during WAIT before the access SHALL abort it with no write.
REQ-030 Deassertion is synchronous to clk, and the first accept is possible on the first edge after release.

Configuration
REQ-031 Macro MEM_RESP_MISALIGN_ERR_EN: when defined, a misaligned half (addr[0]=1) or word (addr[1:0]≠0) SHALL set rsp_err with no write.
REQ-032 When MEM_RESP_MISALIGN_ERR_EN is undefined, the low address bits are forced to the size's alignment, so the access rounds down to the aligned address, and rsp_err flags only range and size errors.

Structure
REQ-033 Package mem_pkg holds the state enum, the req_size encoding constants (SIZE_B, SIZE_H, SIZE_W) and the counter width constant.
REQ-034 One sub-module, lane_align, performs combinational store byte-enable/data steering and load extraction/extension, instantiated once.

Verification
REQ-035 After reset (LATENCY=2): word store 0xDEADBEEF at 0x10; rsp_valid rises 3 cycles after accept with rsp_err=0. A word load from 0x10 then returns 0xDEADBEEF.
REQ-036 Store byte 0x80 at 0x13, then a signed byte load from 0x13 returns 0xFFFFFF80, and an unsigned load returns 0x00000080. A word load from 0x10 returns 0x80ADBEEF.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid, rsp_rdata and req_ready=0 stay stable, then one cycle after rsp_ready=1, req_ready=1.
REQ-038 A word load at 0x1000 with DEPTH_WORDS=1024 returns rsp_err=1 and rsp_rdata=0. A store there leaves all words unchanged.
REQ-039 Pull rst low one cycle after accepting a store of 0x12345678 to 0x20: the state returns to IDLE at once, and a later load from 0x20 returns the prior value.
REQ-040 A half load at 0x21 returns rsp_err=1 when MEM_RESP_MISALIGN_ERR_EN is defined, and returns the half at 0x20 with rsp_err=0 when it is undefined.
